// File: rtl/du_pipe_reg_way0.sv
// Way0 decode->execute pipeline register: two-entry skid buffer (main + skid)
// with a registered ready toward the decoder and flush support.
module du_pipe_reg_way0 #(
   parameter int XLEN   = 64,
   parameter int PID_W  = 2,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [ADDR_W-1:0] instAddr_i,
   input  logic [PID_W-1:0]  way0_pID_i,
   input  logic [4:0]        rdAddr_i,
   input  logic              rdWriteEnable_i,
   input  logic [XLEN-1:0]   rs1ReadData_i,
   input  logic [XLEN-1:0]   rs2ReadData_i,
   input  logic [XLEN-1:0]   imm_i,
   input  logic [6:0]        opCode_i,
   input  logic [2:0]        funct3_i,
   input  logic [6:0]        funct7_i,
   input  logic [5:0]        shamt_i,
   output logic              valid_o,
   input  logic              ex_ready_i,
   output logic [ADDR_W-1:0] instAddr_o,
   output logic [PID_W-1:0]  way0_pID_o,
   output logic [4:0]        rdAddr_o,
   output logic              rdWriteEnable_o,
   output logic [XLEN-1:0]   rs1ReadData_o,
   output logic [XLEN-1:0]   rs2ReadData_o,
   output logic [XLEN-1:0]   imm_o,
   output logic [6:0]        opCode_o,
   output logic [2:0]        funct3_o,
   output logic [6:0]        funct7_o,
   output logic [5:0]        shamt_o
);

   localparam int PW = ADDR_W + PID_W + 5 + 1 + 3 * XLEN + 7 + 3 + 7 + 6;

   // State is the pair {skid_v, main_v}
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b01;
   localparam logic [1:0] ST_TWO   = 2'b11;

   logic [PW-1:0] in_pl;
   logic [PW-1:0] main_pl;
   logic [PW-1:0] skid_pl;
   logic          main_v;
   logic          skid_v;
   logic          ready_q;
   logic          main_we;

   logic          accept;
   logic          issue;
   logic [1:0]    state;
   logic          main_v_n;
   logic          skid_v_n;
   logic          load_main_in;
   logic          load_main_skid;
   logic          load_skid;

   assign in_pl = {instAddr_i, way0_pID_i, rdAddr_i, rdWriteEnable_i, rs1ReadData_i,
                   rs2ReadData_i, imm_i, opCode_i, funct3_i, funct7_i, shamt_i};

   assign accept = valid_i & ready_q;
   assign issue  = main_v & ex_ready_i;
   assign state  = {skid_v, main_v};

   always_comb begin
      main_v_n       = main_v;
      skid_v_n       = skid_v;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush_i) begin
         main_v_n = 1'b0;
         skid_v_n = 1'b0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  main_v_n     = 1'b1;
                  load_main_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (accept && issue) begin
                  load_main_in = 1'b1;
               end else if (accept) begin
                  skid_v_n  = 1'b1;
                  load_skid = 1'b1;
               end else if (issue) begin
                  main_v_n = 1'b0;
               end
            end
            ST_TWO: begin
               if (issue) begin
                  skid_v_n       = 1'b0;
                  load_main_skid = 1'b1;
               end
            end
            default: begin
               main_v_n = 1'b0;
               skid_v_n = 1'b0;
            end
         endcase
      end
   end

   // ready is its own flop so EX-ready never reaches the decoder combinationally
   always_ff @(posedge clk) begin
      if (rst) begin
         main_v  <= 1'b0;
         skid_v  <= 1'b0;
         ready_q <= 1'b1;
         main_pl <= '0;
         skid_pl <= '0;
      end else begin
         main_v  <= main_v_n;
         skid_v  <= skid_v_n;
         ready_q <= ~skid_v_n;
         if (load_main_in) begin
            main_pl <= in_pl;
         end else if (load_main_skid) begin
            main_pl <= skid_pl;
         end
         if (load_skid) begin
            skid_pl <= in_pl;
         end
      end
   end

   assign {instAddr_o, way0_pID_o, rdAddr_o, main_we, rs1ReadData_o, rs2ReadData_o,
           imm_o, opCode_o, funct3_o, funct7_o, shamt_o} = main_pl;

   assign rdWriteEnable_o = main_we & main_v;
   assign valid_o         = main_v;
   assign ready_o         = ready_q;

endmodule

// File: tb/tb_du_pipe_reg_way0.sv
// Directed testbench for du_pipe_reg_way0: reset, streaming, backpressure,
// flush, held-output stability and reset during a stall.
module tb_du_pipe_reg_way0;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] instAddr_i;
   logic [1:0]  way0_pID_i;
   logic [4:0]  rdAddr_i;
   logic        rdWriteEnable_i;
   logic [63:0] rs1ReadData_i;
   logic [63:0] rs2ReadData_i;
   logic [63:0] imm_i;
   logic [6:0]  opCode_i;
   logic [2:0]  funct3_i;
   logic [6:0]  funct7_i;
   logic [5:0]  shamt_i;
   logic        valid_o;
   logic        ex_ready_i;
   logic [31:0] instAddr_o;
   logic [1:0]  way0_pID_o;
   logic [4:0]  rdAddr_o;
   logic        rdWriteEnable_o;
   logic [63:0] rs1ReadData_o;
   logic [63:0] rs2ReadData_o;
   logic [63:0] imm_o;
   logic [6:0]  opCode_o;
   logic [2:0]  funct3_o;
   logic [6:0]  funct7_o;
   logic [5:0]  shamt_o;

   int n_asserts = 0;
   int n_fail    = 0;

   du_pipe_reg_way0 dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
      .instAddr_i(instAddr_i), .way0_pID_i(way0_pID_i), .rdAddr_i(rdAddr_i),
      .rdWriteEnable_i(rdWriteEnable_i), .rs1ReadData_i(rs1ReadData_i),
      .rs2ReadData_i(rs2ReadData_i), .imm_i(imm_i), .opCode_i(opCode_i),
      .funct3_i(funct3_i), .funct7_i(funct7_i), .shamt_i(shamt_i),
      .valid_o(valid_o), .ex_ready_i(ex_ready_i),
      .instAddr_o(instAddr_o), .way0_pID_o(way0_pID_o), .rdAddr_o(rdAddr_o),
      .rdWriteEnable_o(rdWriteEnable_o), .rs1ReadData_o(rs1ReadData_o),
      .rs2ReadData_o(rs2ReadData_o), .imm_o(imm_o), .opCode_o(opCode_o),
      .funct3_o(funct3_o), .funct7_o(funct7_o), .shamt_o(shamt_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] pid, input logic [63:0] imm,
                        input logic [4:0] rd, input logic we);
      valid_i         = v;
      way0_pID_i      = pid;
      instAddr_i      = 32'h8000_0000 + {28'd0, pid, 2'b00};
      imm_i           = imm;
      rdAddr_i        = rd;
      rdWriteEnable_i = we;
      rs1ReadData_i   = 64'h1111_0000 + {62'd0, pid};
      rs2ReadData_i   = 64'h2222_0000 + {62'd0, pid};
      opCode_i        = 7'h33;
      funct3_i        = 3'd0;
      funct7_i        = 7'd0;
      shamt_i         = 6'd0;
   endtask

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_asserts++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Checks the visible handshake plus the identity of the presented instruction
   task automatic checkOutput(input string tag, input logic ev, input logic er, input logic [1:0] epid);
      check({tag, " valid_o"}, {63'd0, valid_o}, {63'd0, ev});
      check({tag, " ready_o"}, {63'd0, ready_o}, {63'd0, er});
      if (ev) begin
         check({tag, " pID"}, {62'd0, way0_pID_o}, {62'd0, epid});
         check({tag, " instAddr"}, {32'd0, instAddr_o}, {32'd0, 32'h8000_0000 + {28'd0, epid, 2'b00}});
      end else begin
         check({tag, " rdWE gated"}, {63'd0, rdWriteEnable_o}, 64'd0);
      end
   endtask

   initial begin
      rst        = 1'b1;
      flush_i    = 1'b0;
      ex_ready_i = 1'b0;
      drive(1'b0, 2'd0, 64'd0, 5'd0, 1'b0);
      tick();
      tick();
      check("reset valid_o", {63'd0, valid_o}, 64'd0);
      check("reset ready_o", {63'd0, ready_o}, 64'd1);
      check("reset rdWE", {63'd0, rdWriteEnable_o}, 64'd0);
      check("reset imm", imm_o, 64'd0);
      rst = 1'b0;
      tick();
      checkOutput("idle", 1'b0, 1'b1, 2'd0);

      // Streaming with EX always ready
      ex_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, i[1:0], 64'h100 + 64'(i), 5'd1, 1'b1);
         tick();
         checkOutput($sformatf("stream%0d", i), 1'b1, 1'b1, i[1:0]);
         check($sformatf("stream%0d rdWE", i), {63'd0, rdWriteEnable_o}, 64'd1);
      end
      drive(1'b0, 2'd0, 64'd0, 5'd0, 1'b0);
      tick();
      checkOutput("stream drain", 1'b0, 1'b1, 2'd0);

      // Backpressure fills both entries
      ex_ready_i = 1'b0;
      drive(1'b1, 2'd1, 64'h201, 5'd2, 1'b1);
      tick();
      checkOutput("bp one", 1'b1, 1'b1, 2'd1);
      drive(1'b1, 2'd2, 64'h202, 5'd3, 1'b1);
      tick();
      checkOutput("bp two", 1'b1, 1'b0, 2'd1);
      drive(1'b0, 2'd0, 64'd0, 5'd0, 1'b0);
      tick();
      checkOutput("bp hold", 1'b1, 1'b0, 2'd1);
      ex_ready_i = 1'b1;
      tick();
      checkOutput("bp issue1", 1'b1, 1'b1, 2'd2);
      check("bp skid imm", imm_o, 64'h202);
      tick();
      checkOutput("bp issue2", 1'b0, 1'b1, 2'd0);

      // Flush while full, with a new instruction offered
      ex_ready_i = 1'b0;
      drive(1'b1, 2'd1, 64'h301, 5'd4, 1'b1);
      tick();
      drive(1'b1, 2'd2, 64'h302, 5'd4, 1'b1);
      tick();
      checkOutput("fl two", 1'b1, 1'b0, 2'd1);
      drive(1'b1, 2'd3, 64'h303, 5'd4, 1'b1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      drive(1'b0, 2'd0, 64'd0, 5'd0, 1'b0);
      checkOutput("fl after", 1'b0, 1'b1, 2'd0);
      ex_ready_i = 1'b1;
      tick();
      checkOutput("fl no stale", 1'b0, 1'b1, 2'd0);

      // Flush in ONE drops an instruction accepted in the same cycle
      ex_ready_i = 1'b0;
      drive(1'b1, 2'd0, 64'h401, 5'd4, 1'b1);
      tick();
      drive(1'b1, 2'd3, 64'h403, 5'd4, 1'b1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      drive(1'b0, 2'd0, 64'd0, 5'd0, 1'b0);
      checkOutput("fl one drop", 1'b0, 1'b1, 2'd0);
      tick();
      checkOutput("fl one idle", 1'b0, 1'b1, 2'd0);

      // Held outputs stay stable through a stall, skid fill included
      drive(1'b1, 2'd0, 64'hFFFF_FFFF_FFFF_F800, 5'd5, 1'b1);
      tick();
      drive(1'b1, 2'd1, 64'h0000_0000_0000_0777, 5'd9, 1'b1);
      tick();
      drive(1'b0, 2'd0, 64'd0, 5'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("stall%0d imm", i), imm_o, 64'hFFFF_FFFF_FFFF_F800);
         check($sformatf("stall%0d rdAddr", i), {59'd0, rdAddr_o}, 64'd5);
         check($sformatf("stall%0d pID", i), {62'd0, way0_pID_o}, 64'd0);
         tick();
      end
      ex_ready_i = 1'b1;
      tick();
      checkOutput("stall release", 1'b1, 1'b1, 2'd1);
      check("stall release imm", imm_o, 64'h777);
      check("stall release rdAddr", {59'd0, rdAddr_o}, 64'd9);
      tick();
      checkOutput("stall drain", 1'b0, 1'b1, 2'd0);

      // Reset during a stall clears both entries
      ex_ready_i = 1'b0;
      drive(1'b1, 2'd2, 64'h502, 5'd6, 1'b1);
      tick();
      drive(1'b1, 2'd3, 64'h503, 5'd7, 1'b1);
      tick();
      checkOutput("rst two", 1'b1, 1'b0, 2'd2);
      drive(1'b0, 2'd0, 64'd0, 5'd0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rst empty", 1'b0, 1'b1, 2'd0);
      check("rst imm", imm_o, 64'd0);
      ex_ready_i = 1'b1;
      tick();
      checkOutput("rst no stale", 1'b0, 1'b1, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
